// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with flush/bubble kill, valid tracking
// and saturating load-use bubble / flush counters.
module id_ex_pipe_reg #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hazard,
    input  logic                 flush,
    input  logic                 cnt_clr,
    input  logic                 RegWriteID,
    input  logic                 MemtoRegID,
    input  logic                 ALUSrcID,
    input  logic                 MemWriteID,
    input  logic                 MemReadID,
    input  logic                 BranchID,
    input  logic                 JALID,
    input  logic                 JALRID,
    input  logic                 AUIPCID,
    input  logic [3:0]           ALU_CCID,
    input  logic [31:0]          InstrID,
    input  logic [WIDTH-1:0]     PCID,
    input  logic [WIDTH-1:0]     RD1ID,
    input  logic [WIDTH-1:0]     RD2ID,
    input  logic [WIDTH-1:0]     ImmID,
    input  logic [4:0]           Addr1ID,
    input  logic [4:0]           Addr2ID,
    input  logic [4:0]           WriteAddrID,
    output logic                 RegWriteEX,
    output logic                 MemtoRegEX,
    output logic                 ALUSrcEX,
    output logic                 MemWriteEX,
    output logic                 MemReadEX,
    output logic                 BranchEX,
    output logic                 JALEX,
    output logic                 JALREX,
    output logic                 AUIPCEX,
    output logic [3:0]           ALU_CCEX,
    output logic [31:0]          InstrEX,
    output logic [WIDTH-1:0]     PCEX,
    output logic [WIDTH-1:0]     RD1EX,
    output logic [WIDTH-1:0]     RD2EX,
    output logic [WIDTH-1:0]     ImmEX,
    output logic [4:0]           Addr1EX,
    output logic [4:0]           Addr2EX,
    output logic [4:0]           WriteAddrEX,
    output logic                 ValidEX,
    output logic [CNT_WIDTH-1:0] bubble_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);
    localparam int BW = 60 + 4 * WIDTH;
    logic [BW-1:0]        bus_d, bus_q;
    logic                 valid_d, valid_q, kill;
    logic [CNT_WIDTH-1:0] bubble_d, bubble_q, flush_d, flush_q;
    always_comb begin
        kill     = flush || !hazard;
        bus_d    = kill ? '0 : {RegWriteID, MemtoRegID, ALUSrcID, MemWriteID, MemReadID, BranchID,
                                JALID, JALRID, AUIPCID, ALU_CCID, InstrID, PCID, RD1ID, RD2ID, ImmID,
                                Addr1ID, Addr2ID, WriteAddrID};
        valid_d  = !kill;
        // a flush that coincides with a bubble counts only as a flush
        bubble_d = cnt_clr ? '0 : (!hazard && !flush && bubble_q != '1) ? bubble_q + CNT_WIDTH'(1) : bubble_q;
        flush_d  = cnt_clr ? '0 : (flush && flush_q != '1) ? flush_q + CNT_WIDTH'(1) : flush_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_q    <= '0;
            valid_q  <= 1'b0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            bus_q    <= bus_d;
            valid_q  <= valid_d;
            bubble_q <= bubble_d;
            flush_q  <= flush_d;
        end
    end
    assign {RegWriteEX, MemtoRegEX, ALUSrcEX, MemWriteEX, MemReadEX, BranchEX, JALEX, JALREX, AUIPCEX,
            ALU_CCEX, InstrEX, PCEX, RD1EX, RD2EX, ImmEX, Addr1EX, Addr2EX, WriteAddrEX} = bus_q;
    assign ValidEX    = valid_q;
    assign bubble_cnt = bubble_q;
    assign flush_cnt  = flush_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed stimulus checked every cycle against a one-cycle-delay
// behavioural model, plus hand-computed literal expectations.
module tb_id_ex_pipe_reg;
    localparam int W  = 32;
    localparam int CW = 4;
    localparam int BW = 60 + 4 * W;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0, reset, hazard, flush, cnt_clr;
    logic RegWriteID, MemtoRegID, ALUSrcID, MemWriteID, MemReadID, BranchID, JALID, JALRID, AUIPCID;
    logic [3:0] ALU_CCID;
    logic [31:0] InstrID;
    logic [W-1:0] PCID, RD1ID, RD2ID, ImmID;
    logic [4:0] Addr1ID, Addr2ID, WriteAddrID;
    logic RegWriteEX, MemtoRegEX, ALUSrcEX, MemWriteEX, MemReadEX, BranchEX, JALEX, JALREX, AUIPCEX;
    logic [3:0] ALU_CCEX;
    logic [31:0] InstrEX;
    logic [W-1:0] PCEX, RD1EX, RD2EX, ImmEX;
    logic [4:0] Addr1EX, Addr2EX, WriteAddrEX;
    logic ValidEX;
    logic [CW-1:0] bubble_cnt, flush_cnt;

    id_ex_pipe_reg #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .hazard(hazard), .flush(flush), .cnt_clr(cnt_clr),
        .RegWriteID(RegWriteID), .MemtoRegID(MemtoRegID), .ALUSrcID(ALUSrcID), .MemWriteID(MemWriteID),
        .MemReadID(MemReadID), .BranchID(BranchID), .JALID(JALID), .JALRID(JALRID), .AUIPCID(AUIPCID),
        .ALU_CCID(ALU_CCID), .InstrID(InstrID), .PCID(PCID), .RD1ID(RD1ID), .RD2ID(RD2ID), .ImmID(ImmID),
        .Addr1ID(Addr1ID), .Addr2ID(Addr2ID), .WriteAddrID(WriteAddrID),
        .RegWriteEX(RegWriteEX), .MemtoRegEX(MemtoRegEX), .ALUSrcEX(ALUSrcEX), .MemWriteEX(MemWriteEX),
        .MemReadEX(MemReadEX), .BranchEX(BranchEX), .JALEX(JALEX), .JALREX(JALREX), .AUIPCEX(AUIPCEX),
        .ALU_CCEX(ALU_CCEX), .InstrEX(InstrEX), .PCEX(PCEX), .RD1EX(RD1EX), .RD2EX(RD2EX), .ImmEX(ImmEX),
        .Addr1EX(Addr1EX), .Addr2EX(Addr2EX), .WriteAddrEX(WriteAddrEX),
        .ValidEX(ValidEX), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    wire [BW-1:0] in_bus = {RegWriteID, MemtoRegID, ALUSrcID, MemWriteID, MemReadID, BranchID, JALID, JALRID,
                            AUIPCID, ALU_CCID, InstrID, PCID, RD1ID, RD2ID, ImmID, Addr1ID, Addr2ID, WriteAddrID};
    wire [BW-1:0] out_bus = {RegWriteEX, MemtoRegEX, ALUSrcEX, MemWriteEX, MemReadEX, BranchEX, JALEX, JALREX,
                             AUIPCEX, ALU_CCEX, InstrEX, PCEX, RD1EX, RD2EX, ImmEX, Addr1EX, Addr2EX, WriteAddrEX};

    int checks = 0, failures = 0;
    logic [BW-1:0] m_bus;
    bit m_valid, model_ok = 1'b0;
    int m_bub, m_fl;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: EX sees last cycle's ID inputs unless reset, flush or bubble killed them.
    always @(posedge clk) begin
        if (reset) begin
            m_bus = '0; m_valid = 0; m_bub = 0; m_fl = 0;
        end else begin
            m_valid = hazard && !flush;
            m_bus   = m_valid ? in_bus : '0;
            if (cnt_clr) begin
                m_bub = 0; m_fl = 0;
            end else if (flush) m_fl = (m_fl < CMAX) ? m_fl + 1 : CMAX;
            else if (!hazard) m_bub = (m_bub < CMAX) ? m_bub + 1 : CMAX;
        end
        model_ok = 1'b1;
    end

    always @(negedge clk) if (model_ok) begin
        check("bus", 256'(out_bus), 256'(m_bus));
        check("valid", 256'(ValidEX), 256'(m_valid));
        check("bubble_cnt", 256'(bubble_cnt), 256'(m_bub));
        check("flush_cnt", 256'(flush_cnt), 256'(m_fl));
    end

    task automatic set_inputs(input logic v);
        {RegWriteID, MemtoRegID, ALUSrcID, MemWriteID, MemReadID, BranchID, JALID, JALRID, AUIPCID,
         ALU_CCID, InstrID, PCID, RD1ID, RD2ID, ImmID, Addr1ID, Addr2ID, WriteAddrID} = {BW{v}};
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_inputs();
        {RegWriteID, MemtoRegID, ALUSrcID, MemWriteID, MemReadID, BranchID, JALID, JALRID, AUIPCID} = 9'($urandom);
        ALU_CCID = 4'($urandom); InstrID = $urandom; PCID = $urandom; RD1ID = $urandom;
        RD2ID = $urandom; ImmID = $urandom; Addr1ID = 5'($urandom); Addr2ID = 5'($urandom);
        WriteAddrID = 5'($urandom);
    endtask

    initial begin
        reset = 1; hazard = 1; flush = 1; cnt_clr = 1; set_inputs(1'b1);
        repeat (2) tick();
        check("rst_instr", 256'(InstrEX), 256'(0));
        check("rst_valid", 256'(ValidEX), 256'(0));
        check("rst_cnts", 256'({bubble_cnt, flush_cnt}), 256'(0));

        reset = 0; flush = 0; cnt_clr = 0; hazard = 1; set_inputs(1'b0);
        InstrID = 32'h00A302B3; RD1ID = 5; RD2ID = 7; RegWriteID = 1; ALU_CCID = 4'b0010; WriteAddrID = 5;
        tick();
        check("cap_instr", 256'(InstrEX), 256'h00A302B3);
        check("cap_rd1", 256'(RD1EX), 256'(5));
        check("cap_rd2", 256'(RD2EX), 256'(7));
        check("cap_regw", 256'(RegWriteEX), 256'(1));
        check("cap_alucc", 256'(ALU_CCEX), 256'(2));
        check("cap_wa", 256'(WriteAddrEX), 256'(5));
        check("cap_valid", 256'(ValidEX), 256'(1));

        hazard = 0; RD1ID = 32'hDEADBEEF;
        tick();
        check("bub_rd1", 256'(RD1EX), 256'(0));
        check("bub_instr", 256'(InstrEX), 256'(0));
        check("bub_valid", 256'(ValidEX), 256'(0));
        check("bub_cnt", 256'(bubble_cnt), 256'(1));
        hazard = 1;
        tick();
        check("bub_restore", 256'(ValidEX), 256'(1));
        check("bub_restore_rd1", 256'(RD1EX), 256'hDEADBEEF);

        hazard = 0; flush = 1;
        tick();
        check("fl_out", 256'(out_bus), 256'(0));
        check("fl_cnt", 256'(flush_cnt), 256'(1));
        check("fl_bub_kept", 256'(bubble_cnt), 256'(1));

        flush = 0;
        repeat (20) tick();
        check("bub_sat", 256'(bubble_cnt), 256'(15));
        cnt_clr = 1;
        tick();
        check("clr_bub", 256'(bubble_cnt), 256'(0));
        check("clr_fl", 256'(flush_cnt), 256'(0));
        cnt_clr = 0; flush = 1;
        repeat (18) tick();
        check("fl_sat", 256'(flush_cnt), 256'(15));
        flush = 0; hazard = 1;

        rand_inputs(); WriteAddrID = 0; RegWriteID = 1;
        tick();
        check("x0_pass", 256'(WriteAddrEX), 256'(0));
        check("x0_regw", 256'(RegWriteEX), 256'(1));
        for (int i = 0; i < 40; i++) begin
            rand_inputs();
            hazard = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 4) == 0);
            cnt_clr = ($urandom_range(0, 15) == 0);
            tick();
        end

        hazard = 1; flush = 0; cnt_clr = 0; rand_inputs(); InstrID = 32'h00000013;
        tick();
        check("mid_a", 256'(InstrEX), 256'h00000013);
        reset = 1; InstrID = 32'h00B50533;
        tick();
        check("mid_rst_out", 256'(out_bus), 256'(0));
        check("mid_rst_valid", 256'(ValidEX), 256'(0));
        reset = 0;
        tick();
        check("mid_b", 256'(InstrEX), 256'h00B50533);
        check("mid_b_valid", 256'(ValidEX), 256'(1));

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core.
- Sits directly downstream of the hazard-detection stage. It captures that stage's gated control signals, the instruction, the register-file read data, the immediate, the PC and the register addresses, and presents them to EX one cycle later.
- Applies branch/jump flush with priority over normal capture and tracks a valid bit.
- Keeps saturating performance counters of load-use bubbles and flushes.

Parameters:
- WIDTH, 32, datapath width of PC, RD1, RD2 and Imm.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- hazard  in  1  from hazard detection; 1 = no hazard, 0 = load-use bubble being inserted.
- flush  in  1  taken branch/JAL/JALR resolved in EX; kill the instruction entering EX.
- cnt_clr  in  1  synchronous clear of both counters.
- RegWriteID, MemtoRegID, ALUSrcID, MemWriteID, MemReadID, BranchID, JALID, JALRID, AUIPCID  in  1 each  gated control from hazard stage.
- ALU_CCID  in  4  ALU condition code.
- InstrID  in  32  gated instruction.
- PCID  in  WIDTH  PC of the ID instruction.
- RD1ID, RD2ID  in  WIDTH  register-file read data.
- ImmID  in  WIDTH  generated immediate.
- Addr1ID, Addr2ID, WriteAddrID  in  5 each  rs1, rs2, rd.
- RegWriteEX … AUIPCEX  out  1 each  registered control (same nine signals).
- ALU_CCEX  out  4  registered ALU code.
- InstrEX  out  32  registered instruction.
- PCEX, RD1EX, RD2EX, ImmEX  out  WIDTH  registered datapath.
- Addr1EX, Addr2EX, WriteAddrEX  out  5 each  registered addresses (to forwarding unit and hazard unit WriteAddr).
- ValidEX  out  1  1 = EX holds a real instruction.
- bubble_cnt  out  CNT_WIDTH  load-use bubbles inserted.
- flush_cnt  out  CNT_WIDTH  flushes applied.

Behaviour:
- Reset: every output, including counters, is 0 on the first rising edge with reset=1. Reset overrides all other inputs. Deasserting reset mid-stream resumes normal capture on the next edge; no partial state is retained.
- Latency: exactly 1 cycle. No enable input; the register captures every cycle. Stalling of PC and IF/ID is handled upstream.
- Per-edge priority: reset > flush > bubble (hazard=0) > normal.
- flush=1: all control outputs, ALU_CCEX, InstrEX, PCEX, RD1EX, RD2EX, ImmEX and all address outputs go to 0; ValidEX=0; flush_cnt increments.
- hazard=0 and flush=0: all outputs go to 0, including the datapath and address fields, regardless of their input values; ValidEX=0; bubble_cnt increments.
- hazard=0 and flush=1 on the same edge: treated as a flush only. flush_cnt increments; bubble_cnt is unchanged.
- Normal (hazard=1, flush=0): every *EX output takes its *ID input; ValidEX=1.
- WriteAddrEX=0 with WriteAddrID=0 passes through unchanged; suppressing x0 writes is not this block's job.
- Counters:
  - unsigned, saturate at 2^CNT_WIDTH−1 (no wrap);
  - cnt_clr=1 zeroes both on that edge and takes precedence over any increment in the same cycle;
  - reset also zeroes them.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive all inputs to 1s with reset=1 for 2 cycles -> every output 0, ValidEX=0, both counters 0.
- Normal capture: hazard=1, flush=0, InstrID=32'h00A302B3, RD1ID=5, RD2ID=7, RegWriteID=1, ALU_CCID=4'b0010, WriteAddrID=5 -> the next cycle shows InstrEX=32'h00A302B3, RD1EX=5, RD2EX=7, RegWriteEX=1, ALU_CCEX=2, WriteAddrEX=5, ValidEX=1.
- Load-use bubble: hazard=0 for one cycle with RD1ID=32'hDEADBEEF -> next cycle all outputs 0, ValidEX=0, bubble_cnt=1; the following normal cycle restores ValidEX=1.
- Flush over bubble: hazard=0 and flush=1 on the same edge -> outputs 0, flush_cnt=1, bubble_cnt unchanged.
- Counter saturation: CNT_WIDTH=4, 20 consecutive bubbles -> bubble_cnt holds 15. Then cnt_clr=1 together with hazard=0 -> bubble_cnt=0 on that edge.
- Reset mid-stream: reset=1 for one cycle between two valid instructions -> all outputs 0 that cycle; the second instruction is captured normally on the following edge.
